// File: rtl/rraw_reader.sv
// Raw capture buffer readout: reads each 768-bit RAM entry and serializes it as 24 x 32-bit stream words.
// Define RRAW_HEADER_EN to frame each pass with a header word and a trailer word.
module rraw_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_last,
  output logic              raw_rena,
  output logic [ADDR_W-1:0] raw_raddr,
  input  logic [255:0]      et_rdata,
  input  logic [255:0]      veto_rdata,
  input  logic [255:0]      veto2_rdata,
  output logic [31:0]       dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              rd_done
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 24;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned LAT_W   = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RD_LAT - 1);

`ifdef RRAW_HEADER_EN
  localparam logic [WORD_W-1:0] HDR_TAG = 32'hCD70_0000;
  localparam logic [WORD_W-1:0] TRL_TAG = 32'hCD7F_0000;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHIFT, HDR, TRL, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHIFT, DONE} state_e;
`endif

  state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                raddr_q, raddr_d;
  logic [ADDR_W-1:0]                last_q, last_d;
  logic [LAT_W-1:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [N_WORDS-1:0][WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]                dout_q, dout_d;
  logic                             valid_q, valid_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             rena_q, rena_d;

`ifdef RRAW_HEADER_EN
  logic [15:0] trl_cnt_c;
  assign trl_cnt_c = (16'(last_q) + 16'd1) * 16'd24;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rena_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          last_d  = rd_last;
          raddr_d = '0;
          busy_d  = 1'b1;
`ifdef RRAW_HEADER_EN
          dout_d  = HDR_TAG | WORD_W'(16'(rd_last));
          valid_d = 1'b1;
          state_d = HDR;
`else
          rena_d  = 1'b1;
          state_d = ISSUE;
`endif
        end
      end
`ifdef RRAW_HEADER_EN
      HDR: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          rena_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      TRL: begin
        if (dout_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`endif
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // rdata is valid in the RD_LAT-th cycle after the raw_rena cycle
        if (cnt_q == LAT_END) begin
          hold_d  = {veto2_rdata, veto_rdata, et_rdata};
          idx_d   = '0;
          dout_d  = et_rdata[WORD_W-1:0];
          valid_d = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      SHIFT: begin
        if (dout_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            if (raddr_q == last_q) begin
`ifdef RRAW_HEADER_EN
              dout_d  = TRL_TAG | WORD_W'(trl_cnt_c);
              valid_d = 1'b1;
              state_d = TRL;
`else
              done_d  = 1'b1;
              state_d = DONE;
`endif
            end else begin
              raddr_d = raddr_q + ADDR_W'(1);
              rena_d  = 1'b1;
              state_d = ISSUE;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            dout_d = hold_q[idx_d];
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        raddr_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      raddr_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rena_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rena_q  <= rena_d;
    end
  end

  assign raw_rena   = rena_q;
  assign raw_raddr  = raddr_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign rd_done    = done_q;

endmodule
